sweep_scheduler: RTL

SWEEP_SCHEDULER -- requirements
Module: sweep_scheduler

---
 rtl/sweep_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sweep_scheduler.sv
// Frequency-sweep sequencer: steps the DDS table address, launches averaged
// measurements at every point and hands each averaged result downstream.
module sweep_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int LAST_ADDR  = 199,
    parameter int TIMEOUT    = 65536
) (
    input  logic                  clk125,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           settle_cycles,
    input  logic [1:0]            avg_log2,
    output logic [ADDR_WIDTH-1:0] address_mem,
    output logic                  meas_start,
    input  logic                  meas_done,
    input  logic signed [31:0]    meas_modulo,
    input  logic signed [31:0]    meas_phase,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ADDR_WIDTH-1:0] res_address,
    output logic signed [31:0]    res_modulo,
    output logic signed [31:0]    res_phase,
    output logic                  res_error,
    output logic                  busy,
    output logic                  fin,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        TRIG   = 3'd2,
        WAIT   = 3'd3,
        OUT    = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int                    TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_END = ADDR_WIDTH'(LAST_ADDR);

    state_t                state;
    state_t                state_next;
    logic [15:0]           settle_q;
    logic [15:0]           settle_cnt;
    logic [1:0]            avg_q;
    logic [3:0]            avg_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic signed [34:0]    acc_mod;
    logic signed [34:0]    acc_ph;
    logic signed [34:0]    sum_mod;
    logic signed [34:0]    sum_ph;
    logic                  settle_last;
    logic                  avg_last;
    logic                  tmo_last;
    logic                  at_last;
    logic                  fin_q;

    // settle_q == 0 still yields one SETTLE cycle: the compare is true at count 0.
    always_comb begin
        sum_mod     = acc_mod + {{3{meas_modulo[31]}}, meas_modulo};
        sum_ph      = acc_ph + {{3{meas_phase[31]}}, meas_phase};
        settle_last = (settle_cnt + 16'd1) >= settle_q;
        avg_last    = (avg_cnt + 4'd1) == (4'd1 << avg_q);
        tmo_last    = tmo_cnt == TMO_LAST;
        at_last     = address_mem == ADDR_END;
    end

    always_ff @(posedge clk125) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort wins over every other event outside IDLE.
    always_comb begin
        state_next = state;
        if (abort && state != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = SETTLE;
                SETTLE:  if (settle_last) state_next = TRIG;
                TRIG:    state_next = WAIT;
                WAIT: begin
                    if (meas_done) begin
                        state_next = avg_last ? OUT : TRIG;
                    end else if (tmo_last) begin
                        state_next = OUT;
                    end
                end
                OUT:     if (res_ready) state_next = NEXT;
                NEXT:    state_next = at_last ? DONE : SETTLE;
                DONE:    if (!start) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Result handshake: res_valid stays high with the payload frozen until an
    // edge where res_valid && res_ready, which is the single transfer.
    always_comb begin
        meas_start = state == TRIG;
        res_valid  = state == OUT;
        busy       = (state == SETTLE) || (state == TRIG) || (state == WAIT) ||
                     (state == OUT) || (state == NEXT);
        fin        = fin_q;
        state_dbg  = state;
    end

    always_ff @(posedge clk125) begin
        if (reset) begin
            settle_q    <= '0;
            settle_cnt  <= '0;
            avg_q       <= '0;
            avg_cnt     <= '0;
            tmo_cnt     <= '0;
            acc_mod     <= '0;
            acc_ph      <= '0;
            address_mem <= '0;
            res_address <= '0;
            res_modulo  <= '0;
            res_phase   <= '0;
            res_error   <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (abort && state != IDLE) begin
                address_mem <= '0;
                acc_mod     <= '0;
                acc_ph      <= '0;
                avg_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            settle_q    <= settle_cycles;
                            avg_q       <= avg_log2;
                            settle_cnt  <= '0;
                            avg_cnt     <= '0;
                            acc_mod     <= '0;
                            acc_ph      <= '0;
                            address_mem <= '0;
                        end
                    end
                    SETTLE: settle_cnt <= settle_cnt + 16'd1;
                    TRIG:   tmo_cnt <= '0;
                    WAIT: begin
                        if (meas_done) begin
                            acc_mod <= sum_mod;
                            acc_ph  <= sum_ph;
                            avg_cnt <= avg_cnt + 4'd1;
                            if (avg_last) begin
                                res_modulo  <= 32'(sum_mod >>> avg_q);
                                res_phase   <= 32'(sum_ph >>> avg_q);
                                res_error   <= 1'b0;
                                res_address <= address_mem;
                            end
                        end else if (tmo_last) begin
                            res_modulo  <= '0;
                            res_phase   <= '0;
                            res_error   <= 1'b1;
                            res_address <= address_mem;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    NEXT: begin
                        settle_cnt <= '0;
                        avg_cnt    <= '0;
                        acc_mod    <= '0;
                        acc_ph     <= '0;
                        if (at_last) begin
                            address_mem <= '0;
                            fin_q       <= 1'b1;
                        end else begin
                            address_mem <= address_mem + ADDR_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
